full_adder: RTL and testbench

Single-bit full adder with a combinational result path and a registered, enable-qualified copy of the result. It is the basic arithmetic cell for lab datapaths, such as ripple-carry adders and counters built by chaining instances through `co` → `ci`. Optional saturating statistics counters support on-board debug.

---
 rtl/full_adder.sv | 62 ++++++
 tb/tb_full_adder.sv | 91 +++++++++
 2 files changed

// File: rtl/full_adder.sv
// full_adder: single-bit full adder with a registered, enable-qualified copy of the result.
// Define FA_STATS_EN to build the saturating ops_cnt/carry_cnt statistics counters.
module full_adder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             b,
   input  logic             ci,
   input  logic             en,
   output logic             sum,
   output logic             co,
   output logic             sum_q,
   output logic             co_q,
   output logic             vld_q,
   output logic [CNT_W-1:0] ops_cnt,
   output logic [CNT_W-1:0] carry_cnt
);
   logic w_sum;
   logic w_co;
   logic r_sum;
   logic r_co;
   logic r_vld;
   assign w_sum = a ^ b ^ ci;
   assign w_co  = (a & b) | (a & ci) | (b & ci);
   assign sum   = w_sum;
   assign co    = w_co;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum <= 1'b0;
         r_co  <= 1'b0;
         r_vld <= 1'b0;
      end else begin
         r_sum <= en ? w_sum : r_sum;
         r_co  <= en ? w_co : r_co;
         r_vld <= en;
      end
   end
   assign sum_q = r_sum;
   assign co_q  = r_co;
   assign vld_q = r_vld;
`ifdef FA_STATS_EN
   logic [CNT_W-1:0] r_ops;
   logic [CNT_W-1:0] r_carry;
   // each counter sticks at all-ones independently instead of wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ops   <= '0;
         r_carry <= '0;
      end else begin
         r_ops   <= (en && !(&r_ops)) ? r_ops + 1'b1 : r_ops;
         r_carry <= (en && w_co && !(&r_carry)) ? r_carry + 1'b1 : r_carry;
      end
   end
   assign ops_cnt   = r_ops;
   assign carry_cnt = r_carry;
`else
   assign ops_cnt   = '0;
   assign carry_cnt = '0;
`endif
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed self-checking bench for full_adder (default and CNT_W=3 instances).
module tb_full_adder;
   logic clk = 1'b0;
   logic rst, a, b, ci, en;
   logic sum, co, sum_q, co_q, vld_q;
   logic [15:0] ops_cnt, carry_cnt;
   logic s_sum, s_co, s_sum_q, s_co_q, s_vld_q;
   logic [2:0] s_ops, s_carry;
   int n_run = 0;
   int n_fail = 0;
`ifdef FA_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   always #5 clk = ~clk;
   full_adder dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .ci(ci), .en(en),
      .sum(sum), .co(co), .sum_q(sum_q), .co_q(co_q), .vld_q(vld_q),
      .ops_cnt(ops_cnt), .carry_cnt(carry_cnt)
   );
   full_adder #(.CNT_W(3)) dut_s (
      .clk(clk), .rst(rst), .a(a), .b(b), .ci(ci), .en(en),
      .sum(s_sum), .co(s_co), .sum_q(s_sum_q), .co_q(s_co_q), .vld_q(s_vld_q),
      .ops_cnt(s_ops), .carry_cnt(s_carry)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step(input logic r, input logic e, input logic ia, input logic ib, input logic ic);
      rst = r;
      en  = e;
      a   = ia;
      b   = ib;
      ci  = ic;
      @(posedge clk);
      #1;
   endtask
   // expected {co,sum} for (a,b,ci) = index bits {a,b,ci}
   logic [1:0] exp_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
   initial begin
      rst = 1'b1; en = 1'b0; a = 1'b0; b = 1'b0; ci = 1'b0;
      for (int i = 0; i < 8; i++) begin
         {a, b, ci} = 3'(i);
         #5;
         check($sformatf("comb%0d", i), {co, sum}, exp_tab[i]);
         check($sformatf("comb_s%0d", i), {s_co, s_sum}, exp_tab[i]);
      end
      step(1, 0, 0, 0, 0);
      check("rst_regs", {sum_q, co_q, vld_q}, 3'b000);
      check("rst_ops", ops_cnt, 0);
      check("rst_carry", carry_cnt, 0);
      step(0, 1, 1, 1, 0);
      check("lat_regs", {sum_q, co_q, vld_q}, 3'b011);
      step(0, 0, 1, 0, 0);
      check("hold_regs", {sum_q, co_q, vld_q}, 3'b010);
      check("hold_comb", {co, sum}, 2'b01);
      check("hold_ops", ops_cnt, STATS ? 1 : 0);
      check("hold_carry", carry_cnt, STATS ? 1 : 0);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 1, i[2], i[1], i[0]);
      check("stat_ops", ops_cnt, STATS ? 8 : 0);
      check("stat_carry", carry_cnt, STATS ? 4 : 0);
      check("stat_ops_w3", s_ops, STATS ? 7 : 0);
      check("stat_carry_w3", s_carry, STATS ? 4 : 0);
      check("stat_regs", {sum_q, co_q, vld_q}, 3'b111);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 1, 1, 1, 1);
      check("sat_ops_w3", s_ops, STATS ? 7 : 0);
      check("sat_carry_w3", s_carry, STATS ? 7 : 0);
      check("sat_ops", ops_cnt, STATS ? 10 : 0);
      check("sat_carry", carry_cnt, STATS ? 10 : 0);
      step(1, 1, 1, 0, 1);
      check("rprio_regs", {sum_q, co_q, vld_q}, 3'b000);
      check("rprio_ops", ops_cnt, 0);
      check("rprio_carry", carry_cnt, 0);
      check("rprio_ops_w3", s_ops, 0);
      check("rprio_carry_w3", s_carry, 0);
      check("rprio_comb", {co, sum}, 2'b10);
      step(0, 1, 0, 0, 1);
      check("post_regs", {sum_q, co_q, vld_q}, 3'b101);
      check("post_ops", ops_cnt, STATS ? 1 : 0);
      check("post_carry", carry_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
